hier_rv_arbiter: RTL and testbench

HIER_RV_ARBITER -- requirements
Module: hier_rv_arbiter

---
 rtl/hier_rv_arbiter_pkg.sv | 37 +++
 rtl/rdy_vld_if.sv | 19 +
 rtl/hier_rv_skid.sv | 78 +++++++
 rtl/hier_rv_arbiter.sv | 164 ++++++++++++++++
 tb/tb_hier_rv_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hier_rv_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hierInclude_package
// Shared types for the hierarchical ready/valid arbiter:
//   arb_state_t   - arbiter FSM state encoding
//   OWNER_*       - one-hot owner encodings {C,B} reported on cur_owner
//   ARB_WEIGHT_W  - width of the per-requester weight / credit fields
//   eff_weight()  - weight as loaded into the credit counter (0 acts as 1)
//   owner_of()    - one-hot owner for a given FSM state
// ---------------------------------------------------------------------------
package hierInclude_package;

   localparam int ARB_WEIGHT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_B = 2'd1,
      SERVE_C = 2'd2
   } arb_state_t;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_B    = 2'b01;
   localparam logic [1:0] OWNER_C    = 2'b10;

   // A zero weight would starve its own requester, so it grants one beat.
   function automatic logic [ARB_WEIGHT_W-1:0] eff_weight(input logic [ARB_WEIGHT_W-1:0] w);
      return (w == '0) ? ARB_WEIGHT_W'(1) : w;
   endfunction

   function automatic logic [1:0] owner_of(input arb_state_t s);
      case (s)
         SERVE_B: return OWNER_B;
         SERVE_C: return OWNER_C;
         default: return OWNER_NONE;
      endcase
   endfunction

endpackage

// File: rtl/rdy_vld_if.sv
// ---------------------------------------------------------------------------
// rdy_vld_if
// Ready/valid channel. A beat transfers on a rising clock edge where both
// vld and rdy are high.
//   vld  - source has a beat on data
//   rdy  - destination accepts the beat
//   data - payload, DATA_W bits
// Modports: src (drives vld/data), dst (drives rdy).
// ---------------------------------------------------------------------------
interface rdy_vld_if #(
   parameter int DATA_W = 32
);
   logic              vld;
   logic              rdy;
   logic [DATA_W-1:0] data;

   modport src (output vld, output data, input rdy);
   modport dst (input vld, input data, output rdy);
endinterface

// File: rtl/hier_rv_skid.sv
// ---------------------------------------------------------------------------
// hier_rv_skid
// Two-entry skid buffer with registered outputs. One cycle of latency and
// full throughput while out_rdy stays high. in_rdy depends only on local
// state (buffer not full), never on out_rdy in the same cycle.
// Used by hier_rv_arbiter when HIER_RV_ARBITER_SKID_EN is defined.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   in_vld/in_data     - upstream beat
//   in_rdy             - buffer not full
//   out_vld/out_data   - registered downstream beat
//   out_rdy            - downstream accept
// ---------------------------------------------------------------------------
module hier_rv_skid #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_rdy,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_rdy
);

   logic              out_vld_q,  out_vld_d;
   logic              skid_vld_q, skid_vld_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              push;

   // Full means both the output register and the skid register hold beats.
   assign in_rdy   = ~skid_vld_q;
   assign push     = in_vld & ~skid_vld_q;
   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;

   always_comb begin
      out_vld_d   = out_vld_q;
      skid_vld_d  = skid_vld_q;
      out_data_d  = out_data_q;
      skid_data_d = skid_data_q;
      if (!out_vld_q || out_rdy) begin
         // Output slot frees up: the oldest beat (skid first) moves in.
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = skid_data_q;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = push;
            if (push) out_data_d = in_data;
         end
      end else if (push) begin
         // Output stalled: park the incoming beat behind it.
         skid_vld_d  = 1'b1;
         skid_data_d = in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   // NOTE: payload registers are deliberately left out of reset; the valid
   // flags alone decide whether their contents mean anything.
   always_ff @(posedge clk) begin
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
   end

endmodule

// File: rtl/hier_rv_arbiter.sv
// ---------------------------------------------------------------------------
// hier_rv_arbiter
// Weighted round-robin between two ready/valid requesters (B, C) onto one
// shared downstream channel. The owner keeps the channel for up to its
// weight in consecutive beats; ownership only moves on a beat boundary.
// Build option: define HIER_RV_ARBITER_SKID_EN to insert a 2-entry output
// skid buffer (hier_rv_skid); otherwise outS is a combinational pass-through.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   inB, inC                   - requester channels (arbiter drives rdy)
//   outS                       - shared downstream channel
//   cfg_weight_b/c             - beats per turn, sampled at each credit load
//   grant_cnt_b/c              - wrapping counts of beats accepted per requester
//   cur_owner                  - one-hot owner {C,B}, 2'b00 when idle
// ---------------------------------------------------------------------------
module hier_rv_arbiter
   import hierInclude_package::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rdy_vld_if.dst                  inB,
   rdy_vld_if.dst                  inC,
   rdy_vld_if.src                  outS,
   input  logic [ARB_WEIGHT_W-1:0] cfg_weight_b,
   input  logic [ARB_WEIGHT_W-1:0] cfg_weight_c,
   output logic [CNT_W-1:0]        grant_cnt_b,
   output logic [CNT_W-1:0]        grant_cnt_c,
   output logic [1:0]              cur_owner
);

   arb_state_t              state_q,  state_d;
   logic [ARB_WEIGHT_W-1:0] credit_q, credit_d;
   logic [CNT_W-1:0]        cnt_b_q,  cnt_b_d;
   logic [CNT_W-1:0]        cnt_c_q,  cnt_c_d;
   logic [1:0]              owner_q,  owner_d;

   logic              own_b, own_c;
   logic              accept;
   logic              xfer_b, xfer_c;
   logic              mux_vld;
   logic [DATA_W-1:0] mux_data;

   assign own_b = (state_q == SERVE_B);
   assign own_c = (state_q == SERVE_C);

   // Only the owner sees ready; all accounting uses this input-side handshake.
   assign inB.rdy = own_b & accept;
   assign inC.rdy = own_c & accept;
   assign xfer_b  = inB.vld & inB.rdy;
   assign xfer_c  = inC.vld & inC.rdy;

   always_comb begin
      // NOTE: defaults come first so every path assigns every output of this
      // block; a missing assignment would infer a latch.
      mux_vld  = 1'b0;
      mux_data = '0;
      if (own_b) begin
         mux_vld  = inB.vld;
         mux_data = inB.data;
      end else if (own_c) begin
         mux_vld  = inC.vld;
         mux_data = inC.data;
      end
   end

`ifdef HIER_RV_ARBITER_SKID_EN
   hier_rv_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (mux_vld),
      .in_data  (mux_data),
      .in_rdy   (accept),
      .out_vld  (outS.vld),
      .out_data (outS.data),
      .out_rdy  (outS.rdy)
   );
`else
   assign outS.vld  = mux_vld;
   assign outS.data = mux_data;
   assign accept    = outS.rdy;
`endif

   always_comb begin
      state_d  = state_q;
      credit_d = credit_q;
      cnt_b_d  = xfer_b ? cnt_b_q + 1'b1 : cnt_b_q;
      cnt_c_d  = xfer_c ? cnt_c_q + 1'b1 : cnt_c_q;
      case (state_q)
         IDLE: begin
            // B wins a simultaneous request from idle.
            if (inB.vld) begin
               state_d  = SERVE_B;
               credit_d = eff_weight(cfg_weight_b);
            end else if (inC.vld) begin
               state_d  = SERVE_C;
               credit_d = eff_weight(cfg_weight_c);
            end
         end
         SERVE_B: begin
            if (xfer_b) credit_d = credit_q - 1'b1;
            // Leave on the last credited beat or when B has nothing pending;
            // never while a B beat is waiting to be accepted.
            if ((xfer_b && credit_q == ARB_WEIGHT_W'(1)) || !inB.vld) begin
               if (inC.vld) begin
                  state_d  = SERVE_C;
                  credit_d = eff_weight(cfg_weight_c);
               end else if (inB.vld) begin
                  credit_d = eff_weight(cfg_weight_b);
               end else begin
                  state_d  = IDLE;
                  credit_d = '0;
               end
            end
         end
         SERVE_C: begin
            if (xfer_c) credit_d = credit_q - 1'b1;
            if ((xfer_c && credit_q == ARB_WEIGHT_W'(1)) || !inC.vld) begin
               if (inB.vld) begin
                  state_d  = SERVE_B;
                  credit_d = eff_weight(cfg_weight_b);
               end else if (inC.vld) begin
                  credit_d = eff_weight(cfg_weight_c);
               end else begin
                  state_d  = IDLE;
                  credit_d = '0;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase
      owner_d = owner_of(state_d);
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         credit_q <= '0;
         cnt_b_q  <= '0;
         cnt_c_q  <= '0;
         owner_q  <= OWNER_NONE;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         cnt_b_q  <= cnt_b_d;
         cnt_c_q  <= cnt_c_d;
         owner_q  <= owner_d;
      end
   end

   assign grant_cnt_b = cnt_b_q;
   assign grant_cnt_c = cnt_c_q;
   assign cur_owner   = owner_q;

endmodule

// File: tb/tb_hier_rv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hier_rv_arbiter
// Randomized and directed stimulus for hier_rv_arbiter, checked each cycle
// against a transaction-level reference model (owner/credit rules, a plain
// queue for the optional skid buffer, per-requester scoreboards).
// ---------------------------------------------------------------------------
module tb_hier_rv_arbiter;
   import hierInclude_package::*;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
`ifdef HIER_RV_ARBITER_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [ARB_WEIGHT_W-1:0] cfg_weight_b, cfg_weight_c;
   logic [CNT_W-1:0]        grant_cnt_b, grant_cnt_c;
   logic [1:0]              cur_owner;

   rdy_vld_if #(.DATA_W(DATA_W)) b_if ();
   rdy_vld_if #(.DATA_W(DATA_W)) c_if ();
   rdy_vld_if #(.DATA_W(DATA_W)) s_if ();

   always #5 clk = ~clk;

   hier_rv_arbiter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inB          (b_if),
      .inC          (c_if),
      .outS         (s_if),
      .cfg_weight_b (cfg_weight_b),
      .cfg_weight_c (cfg_weight_c),
      .grant_cnt_b  (grant_cnt_b),
      .grant_cnt_c  (grant_cnt_c),
      .cur_owner    (cur_owner)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int          src;
      logic [31:0] data;
   } beat_t;

   int          m_owner;        // 0 none, 1 B, 2 C
   int          m_credit;
   int unsigned m_cnt_b, m_cnt_c;
   beat_t       m_buf[$];       // beats held in the skid buffer (skid build)
   logic [31:0] sent_b[$], sent_c[$];
   int          out_src_log[$];

   // ---------------- driver controls ----------------
   int b_rate, c_rate;          // % chance to present a new beat
   int rdy_mode;                // 0 always, 1 random, 2 toggle, 3 stalled
   bit b_force;                 // next B beat carries 0xDEADBEEF

   function automatic int eff_w(input int w);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic logic [63:0] wrap_cnt(input int unsigned c);
      return 64'(c % (1 << CNT_W));
   endfunction

   task automatic model_clear();
      m_owner  = 0;
      m_credit = 0;
      m_cnt_b  = 0;
      m_cnt_c  = 0;
      m_buf.delete();
      sent_b.delete();
      sent_c.delete();
   endtask

   task automatic model_arbitrate(input bit vb, input bit vc, input bit xb, input bit xc,
                                  input int wb, input int wc);
      bit v[3];
      bit x[3];
      int w[3];
      int o, y;
      v[1] = vb; v[2] = vc; x[1] = xb; x[2] = xc; w[1] = eff_w(wb); w[2] = eff_w(wc);
      if (m_owner == 0) begin
         if (vb)      begin m_owner = 1; m_credit = w[1]; end
         else if (vc) begin m_owner = 2; m_credit = w[2]; end
      end else begin
         o = m_owner;
         y = 3 - o;
         if (x[o]) m_credit--;
         if ((x[o] && m_credit == 0) || !v[o]) begin
            if (v[y])      begin m_owner = y; m_credit = w[y]; end
            else if (v[o]) m_credit = w[o];
            else           begin m_owner = 0; m_credit = 0; end
         end
      end
   endtask

   task automatic drive_next(input bit xb, input bit xc);
      if (xb || !b_if.vld) begin
         if (b_rate > 0 && $urandom_range(0, 99) < b_rate) begin
            b_if.vld  = 1'b1;
            b_if.data = b_force ? 32'hDEADBEEF : $urandom();
            b_force   = 1'b0;
         end else begin
            b_if.vld = 1'b0;
         end
      end
      if (xc || !c_if.vld) begin
         if (c_rate > 0 && $urandom_range(0, 99) < c_rate) begin
            c_if.vld  = 1'b1;
            c_if.data = $urandom();
         end else begin
            c_if.vld = 1'b0;
         end
      end
      case (rdy_mode)
         0:       s_if.rdy = 1'b1;
         1:       s_if.rdy = 1'($urandom_range(0, 1));
         2:       s_if.rdy = ~s_if.rdy;
         default: s_if.rdy = 1'b0;
      endcase
   endtask

   // One clock: check at the falling edge, advance the model, drive after the rising edge.
   task automatic cycle();
      bit          accept, exp_b_rdy, exp_c_rdy, xb, xc, exp_vld, out_hs;
      logic [31:0] exp_data;
      logic [1:0]  exp_owner;
      int          exp_src;
      beat_t       nb;
      @(negedge clk);
      accept    = SKID ? (m_buf.size() < 2) : s_if.rdy;
      exp_b_rdy = (m_owner == 1) && accept;
      exp_c_rdy = (m_owner == 2) && accept;
      exp_owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      exp_data  = '0;
      exp_src   = 0;
      if (SKID) begin
         exp_vld = (m_buf.size() > 0);
         if (exp_vld) begin
            exp_data = m_buf[0].data;
            exp_src  = m_buf[0].src;
         end
      end else begin
         exp_vld  = (m_owner == 1) ? b_if.vld : (m_owner == 2) ? c_if.vld : 1'b0;
         exp_data = (m_owner == 1) ? b_if.data : c_if.data;
         exp_src  = m_owner;
      end
      check("inB.rdy", b_if.rdy, exp_b_rdy);
      check("inC.rdy", c_if.rdy, exp_c_rdy);
      check("cur_owner", cur_owner, exp_owner);
      check("outS.vld", s_if.vld, exp_vld);
      if (exp_vld) check("outS.data", s_if.data, exp_data);
      check("grant_cnt_b", grant_cnt_b, wrap_cnt(m_cnt_b));
      check("grant_cnt_c", grant_cnt_c, wrap_cnt(m_cnt_c));

      xb     = b_if.vld && exp_b_rdy;
      xc     = c_if.vld && exp_c_rdy;
      out_hs = exp_vld && s_if.rdy;
      if (xb) begin sent_b.push_back(b_if.data); m_cnt_b++; end
      if (xc) begin sent_c.push_back(c_if.data); m_cnt_c++; end
      if (out_hs) begin
         out_src_log.push_back(exp_src);
         if (exp_src == 1) begin
            check("sb_b_depth", sent_b.size() > 0, 1'b1);
            if (sent_b.size() > 0) check("sb_b_order", s_if.data, sent_b.pop_front());
         end else begin
            check("sb_c_depth", sent_c.size() > 0, 1'b1);
            if (sent_c.size() > 0) check("sb_c_order", s_if.data, sent_c.pop_front());
         end
      end
      if (SKID) begin
         if (out_hs) void'(m_buf.pop_front());
         if (xb) begin nb.src = 1; nb.data = b_if.data; m_buf.push_back(nb); end
         if (xc) begin nb.src = 2; nb.data = c_if.data; m_buf.push_back(nb); end
      end
      model_arbitrate(b_if.vld, c_if.vld, xb, xc, int'(cfg_weight_b), int'(cfg_weight_c));
      @(posedge clk);
      #1;
      drive_next(xb, xc);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      b_if.vld = 1'b0;
      c_if.vld = 1'b0;
      #1;
      check("rst_outS.vld", s_if.vld, 1'b0);
      check("rst_inB.rdy", b_if.rdy, 1'b0);
      check("rst_inC.rdy", c_if.rdy, 1'b0);
      check("rst_grant_cnt_b", grant_cnt_b, 0);
      check("rst_grant_cnt_c", grant_cnt_c, 0);
      check("rst_cur_owner", cur_owner, 2'b00);
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drive_next(1'b1, 1'b1);
   endtask

   int exp_order[6] = '{1, 1, 2, 1, 1, 2};

   initial begin
      rst_n        = 1'b0;
      b_if.vld     = 1'b0;
      b_if.data    = '0;
      c_if.vld     = 1'b0;
      c_if.data    = '0;
      s_if.rdy     = 1'b1;
      cfg_weight_b = 4'd2;
      cfg_weight_c = 4'd1;
      b_rate = 0; c_rate = 0; rdy_mode = 0; b_force = 1'b0;
      model_clear();

      // Both always valid, weights 2/1: output order B,B,C,B,B,C.
      b_rate = 100; c_rate = 100;
      do_reset();
      out_src_log.delete();
      begin
         bit cnt_seen = 1'b0;
         for (int i = 0; i < 40 && out_src_log.size() < 6; i++) begin
            cycle();
            if (!cnt_seen && m_cnt_b + m_cnt_c == 6) begin
               cnt_seen = 1'b1;
               check("wrr_cnt_b", grant_cnt_b, 4);
               check("wrr_cnt_c", grant_cnt_c, 2);
            end
         end
      end
      check("wrr_beats", out_src_log.size() >= 6, 1'b1);
      for (int i = 0; i < 6 && i < out_src_log.size(); i++)
         check($sformatf("wrr_order[%0d]", i), out_src_log[i], exp_order[i]);

      // Only C, weight 0 acts as 1: back-to-back beats, owner stays C.
      b_rate = 0; c_rate = 100; cfg_weight_c = 4'd0;
      do_reset();
      for (int i = 0; i < 40 && m_cnt_c < 5; i++) begin
         cycle();
         if (m_cnt_c >= 1) check("c_only_owner", cur_owner, 2'b10);
         check("c_only_b_rdy", b_if.rdy, 1'b0);
      end
      check("c_only_cnt", grant_cnt_c, 5);

      // B holds 0xDEADBEEF against a stalled sink while C waits.
      b_rate = 100; c_rate = 100; cfg_weight_b = 4'd1; cfg_weight_c = 4'd1; rdy_mode = 3;
      b_force = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (s_if.vld) check("stall_data", s_if.data, 32'hDEADBEEF);
`ifndef HIER_RV_ARBITER_SKID_EN
         check("stall_owner", cur_owner, 2'b01);
`endif
      end
      rdy_mode = 0;
      repeat (6) cycle();

      // Reset in the middle of a burst with beats in flight.
      b_rate = 100; c_rate = 100; cfg_weight_b = 4'd3; cfg_weight_c = 4'd3; rdy_mode = 3;
      do_reset();
      repeat (4) cycle();
      b_rate = 100; c_rate = 0; rdy_mode = 0;
      do_reset();
      repeat (6) cycle();

      // Toggling sink ready with both requesters busy.
      b_rate = 100; c_rate = 100; rdy_mode = 2;
      cfg_weight_b = 4'($urandom_range(0, 15)); cfg_weight_c = 4'($urandom_range(0, 15));
      do_reset();
      repeat (60) cycle();

      // Random segments, with a reset landing mid-traffic partway through.
      for (int seg = 0; seg < 6; seg++) begin
         cfg_weight_b = 4'($urandom_range(0, 15));
         cfg_weight_c = 4'($urandom_range(0, 15));
         b_rate   = $urandom_range(20, 100);
         c_rate   = $urandom_range(20, 100);
         rdy_mode = 1;
         if (seg == 3) do_reset();
         for (int i = 0; i < 300; i++) begin
            cycle();
            if (i == 150) cfg_weight_b = 4'($urandom_range(0, 15));
         end
      end

      // Drain everything accepted so far.
      b_rate = 0; c_rate = 0; rdy_mode = 0;
      repeat (10) cycle();
      check("drain_b", sent_b.size(), 0);
      check("drain_c", sent_c.size(), 0);

      // Grant counter wraps: 65537 B beats leave grant_cnt_b at 1.
      b_rate = 100; c_rate = 0; rdy_mode = 0; cfg_weight_b = 4'd15;
      do_reset();
      for (int i = 0; i < 70000 && m_cnt_b < 65537; i++) cycle();
      check("wrap_count_reached", m_cnt_b, 65537);
      check("wrap_grant_cnt_b", grant_cnt_b, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
